branch_resolve_queue: RTL and testbench

// - Holds the in-order queue of predictions made at fetch. At execute it pops the oldest entry and

---
 rtl/branch_resolve_queue.sv | 178 +++++++++++++++++
 tb/tb_branch_resolve_queue.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order queue of fetch-time branch predictions.
// Execute pops the oldest entry, checks it against the resolved outcome and
// drives a registered old_* update/recovery bundle to the branch predictor.
// A mispredict flushes every younger wrong-path entry.
// Optional feature: define BRQ_STATS_EN to add saturating branch and
// mispredict counters (stat_branches, stat_mispred).
module branch_resolve_queue #(
    parameter int DEPTH_LOG = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 push_valid,
    input  logic                 push_cond,
    input  logic [31:0]          push_pc,
    input  logic                 push_pred_taken,
    input  logic [31:0]          push_pred_pc,
    output logic                 push_ready,
    input  logic                 res_valid,
    input  logic                 res_taken,
    input  logic [31:0]          res_target,
    output logic [31:0]          old_pc,
    output logic [31:0]          old_branch_pc,
    output logic [31:0]          old_predict_pc,
    output logic                 old_predict,
    output logic                 old_actual,
    output logic                 old_branch,
    output logic                 mispredict,
    output logic [DEPTH_LOG:0]   count,
    output logic                 underflow
`ifdef BRQ_STATS_EN
    ,
    output logic [31:0]          stat_branches,
    output logic [31:0]          stat_mispred
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG-1:0] PTR_ONE = DEPTH_LOG'(1);
    localparam logic [DEPTH_LOG:0]   CNT_ONE = (DEPTH_LOG + 1)'(1);

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_t;

    state_t state, state_next;

    logic [31:0]          pc_mem      [DEPTH];
    logic [31:0]          pred_pc_mem [DEPTH];
    logic                 taken_mem   [DEPTH];
    logic                 cond_mem    [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr;
    logic [DEPTH_LOG-1:0] rd_ptr;

    logic        full;
    logic        empty;
    logic        pop_fire;
    logic        pop_miss;
    logic        push_fire;
    logic [31:0] actual_next;
    logic        miss;

    // count never exceeds DEPTH, so its top bit alone means full
    assign full       = count[DEPTH_LOG];
    assign empty      = (count == '0);
    assign push_ready = ~full;

    // Head comparison and push/pop qualification; a full queue still takes a
    // push when the head pops in the same cycle, and a mispredicting pop
    // discards any push alongside it because that push is on the wrong path
    always_comb begin
        pop_fire    = res_valid & ~stall & ~empty;
        actual_next = res_taken ? res_target : (pc_mem[rd_ptr] + 32'd4);
        miss        = (res_taken != taken_mem[rd_ptr]) |
                      (pred_pc_mem[rd_ptr] != actual_next);
        pop_miss    = pop_fire & miss;
        push_fire   = push_valid & ~stall & (state == RUN) &
                      (~full | pop_fire) & ~pop_miss;
    end

    // Next-state logic: a one-cycle RECOVER window while the predictor redirects
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (pop_miss) state_next = RECOVER;
            RECOVER: state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    // Prediction storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (push_fire) begin
            pc_mem[wr_ptr]      <= push_pc;
            pred_pc_mem[wr_ptr] <= push_pred_pc;
            taken_mem[wr_ptr]   <= push_pred_taken;
            cond_mem[wr_ptr]    <= push_cond;
        end
    end

    // Pointers and occupancy; a mispredict empties the queue by snapping rd_ptr to wr_ptr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (pop_miss) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_fire)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_fire, pop_fire})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Registered update bundle: valid for exactly one cycle after a pop, otherwise all zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            old_pc         <= '0;
            old_branch_pc  <= '0;
            old_predict_pc <= '0;
            old_predict    <= 1'b0;
            old_actual     <= 1'b0;
            old_branch     <= 1'b0;
            mispredict     <= 1'b0;
        end else if (pop_fire) begin
            old_pc         <= actual_next;
            old_branch_pc  <= pc_mem[rd_ptr];
            old_predict_pc <= pred_pc_mem[rd_ptr];
            old_predict    <= taken_mem[rd_ptr];
            old_actual     <= res_taken;
            old_branch     <= cond_mem[rd_ptr];
            mispredict     <= miss;
        end else begin
            old_pc         <= '0;
            old_branch_pc  <= '0;
            old_predict_pc <= '0;
            old_predict    <= 1'b0;
            old_actual     <= 1'b0;
            old_branch     <= 1'b0;
            mispredict     <= 1'b0;
        end
    end

    // Sticky flag for a resolve that arrives with nothing to resolve
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 underflow <= 1'b0;
        else if (res_valid & ~stall & empty)     underflow <= 1'b1;
    end

`ifdef BRQ_STATS_EN
    // Saturating pop and mispredict counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else begin
            if (pop_fire && stat_branches != 32'hFFFF_FFFF)
                stat_branches <= stat_branches + 32'd1;
            if (pop_miss && stat_mispred != 32'hFFFF_FFFF)
                stat_mispred <= stat_mispred + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: scoreboard bench for branch_resolve_queue.
// Each driven cycle updates a reference queue model and pushes the expected
// bundle/count/flags; the scenario task pops and compares one cycle later.
module tb_branch_resolve_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        push_valid = 1'b0;
    logic        push_cond = 1'b0;
    logic [31:0] push_pc = '0;
    logic        push_pred_taken = 1'b0;
    logic [31:0] push_pred_pc = '0;
    logic        push_ready;
    logic        res_valid = 1'b0;
    logic        res_taken = 1'b0;
    logic [31:0] res_target = '0;
    logic [31:0] old_pc, old_branch_pc, old_predict_pc;
    logic        old_predict, old_actual, old_branch, mispredict;
    logic [2:0]  count;
    logic        underflow;
`ifdef BRQ_STATS_EN
    logic [31:0] stat_branches, stat_mispred;
`endif

    branch_resolve_queue #(.DEPTH_LOG(2)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .push_valid(push_valid), .push_cond(push_cond), .push_pc(push_pc),
        .push_pred_taken(push_pred_taken), .push_pred_pc(push_pred_pc),
        .push_ready(push_ready),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .old_pc(old_pc), .old_branch_pc(old_branch_pc), .old_predict_pc(old_predict_pc),
        .old_predict(old_predict), .old_actual(old_actual), .old_branch(old_branch),
        .mispredict(mispredict), .count(count), .underflow(underflow)
`ifdef BRQ_STATS_EN
        , .stat_branches(stat_branches), .stat_mispred(stat_mispred)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic pv; logic pcond; logic [31:0] ppc; logic pt; logic [31:0] ppred;
        logic rv; logic rt; logic [31:0] rtgt; logic st;
    } row_t;

    typedef struct {
        logic [31:0] pc; logic cond; logic taken; logic [31:0] pred_pc;
    } entry_t;

    typedef struct {
        logic [99:0] bundle; logic [2:0] cnt; logic ready; logic under;
    } exp_t;

    entry_t mq[$];
    exp_t   exp_q[$];
    logic   m_under   = 1'b0;
    logic   m_recover = 1'b0;
    int     checks = 0;
    int     fails  = 0;

    function automatic logic [99:0] obs_bundle();
        return {old_pc, old_branch_pc, old_predict_pc, old_predict, old_actual, old_branch, mispredict};
    endfunction

    function automatic row_t mk(logic pv, logic pcond, logic [31:0] ppc, logic pt,
                                logic [31:0] ppred, logic rv, logic rt,
                                logic [31:0] rtgt, logic st);
        row_t r;
        r.pv = pv; r.pcond = pcond; r.ppc = ppc; r.pt = pt; r.ppred = ppred;
        r.rv = rv; r.rt = rt; r.rtgt = rtgt; r.st = st;
        return r;
    endfunction

    // Drive one cycle, advance the reference model and queue the expected result
    task automatic drive(input row_t r);
        exp_t   e;
        entry_t h;
        entry_t n;
        logic   popping, push_ok, mis;
        logic [31:0] act;
        push_valid = r.pv; push_cond = r.pcond; push_pc = r.ppc;
        push_pred_taken = r.pt; push_pred_pc = r.ppred;
        res_valid = r.rv; res_taken = r.rt; res_target = r.rtgt; stall = r.st;
        popping = r.rv && !r.st && (mq.size() != 0);
        if (r.rv && !r.st && mq.size() == 0) m_under = 1'b1;
        push_ok = r.pv && !r.st && !m_recover && (mq.size() < 4 || popping);
        mis = 1'b0;
        e.bundle = '0;
        if (popping) begin
            h   = mq.pop_front();
            act = r.rt ? r.rtgt : h.pc + 32'd4;
            mis = (r.rt != h.taken) || (h.pred_pc != act);
            e.bundle = {act, h.pc, h.pred_pc, h.taken, r.rt, h.cond, mis};
        end
        if (mis) mq.delete();
        else if (push_ok) begin
            n.pc = r.ppc; n.cond = r.pcond; n.taken = r.pt; n.pred_pc = r.ppred;
            mq.push_back(n);
        end
        m_recover = mis;
        e.cnt   = 3'(mq.size());
        e.ready = (mq.size() < 4);
        e.under = m_under;
        exp_q.push_back(e);
        @(posedge clk); #1;
        push_valid = 1'b0; res_valid = 1'b0; stall = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({obs_bundle(), count, underflow} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got %h/%0d/%b required 0/0/0", obs_bundle(), count, underflow);
        end
        checks++;
        if (push_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_push_ready: got %b required 1", push_ready);
        end
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_correct_prediction();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(1, 1, 32'h100, 1, 32'h140, 0, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h140, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = exp_q.pop_front();
            checks++;
            if (obs_bundle() !== e.bundle) begin
                fails++;
                $display("[TB] FAIL correct[%0d] bundle: got %h required %h", i, obs_bundle(), e.bundle);
            end
            checks++;
            if ({count, push_ready, underflow} !== {e.cnt, e.ready, e.under}) begin
                fails++;
                $display("[TB] FAIL correct[%0d] cnt/ready/under: got %0d/%b/%b required %0d/%b/%b",
                         i, count, push_ready, underflow, e.cnt, e.ready, e.under);
            end
        end
    endtask

    task automatic test_mispredict();
        row_t rows[$];
        exp_t e;
        // direction miss with two younger entries and a push alongside the pop
        rows.push_back(mk(1, 1, 32'h200, 0, 32'h204, 0, 0, 0, 0));
        rows.push_back(mk(1, 1, 32'h204, 0, 32'h208, 0, 0, 0, 0));
        rows.push_back(mk(1, 0, 32'h208, 1, 32'h800, 0, 0, 0, 0));
        rows.push_back(mk(1, 1, 32'h20C, 0, 32'h210, 1, 1, 32'h180, 0));
        rows.push_back(mk(1, 1, 32'h180, 0, 32'h184, 0, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        // target miss on an unconditional jump
        rows.push_back(mk(1, 0, 32'h2F0, 1, 32'h300, 0, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h340, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = exp_q.pop_front();
            checks++;
            if (obs_bundle() !== e.bundle) begin
                fails++;
                $display("[TB] FAIL mispred[%0d] bundle: got %h required %h", i, obs_bundle(), e.bundle);
            end
            checks++;
            if ({count, push_ready, underflow} !== {e.cnt, e.ready, e.under}) begin
                fails++;
                $display("[TB] FAIL mispred[%0d] cnt/ready/under: got %0d/%b/%b required %0d/%b/%b",
                         i, count, push_ready, underflow, e.cnt, e.ready, e.under);
            end
        end
    endtask

    function automatic logic [31:0] f_pc(int k);  return 32'h1000 + 32'(k) * 32'h10; endfunction
    function automatic logic [31:0] f_tgt(int k); return 32'h2000 + 32'(k) * 32'h10; endfunction
    function automatic logic        f_tk(int k);  return k[0]; endfunction
    function automatic logic [31:0] f_pred(int k); return f_tk(k) ? f_tgt(k) : f_pc(k) + 32'd4; endfunction

    task automatic test_fill_wrap();
        row_t rows[$];
        exp_t e;
        for (int k = 0; k < 5; k++)
            rows.push_back(mk(1, 1, f_pc(k), f_tk(k), f_pred(k), 0, 0, 0, 0));
        for (int j = 0; j < 4; j++)
            rows.push_back(mk(1, 1, f_pc(5 + j), f_tk(5 + j), f_pred(5 + j),
                              1, f_tk(j), f_tgt(j), 0));
        for (int j = 5; j < 9; j++)
            rows.push_back(mk(0, 0, 0, 0, 0, 1, f_tk(j), f_tgt(j), 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = exp_q.pop_front();
            checks++;
            if (obs_bundle() !== e.bundle) begin
                fails++;
                $display("[TB] FAIL fill[%0d] bundle: got %h required %h", i, obs_bundle(), e.bundle);
            end
            checks++;
            if ({count, push_ready, underflow} !== {e.cnt, e.ready, e.under}) begin
                fails++;
                $display("[TB] FAIL fill[%0d] cnt/ready/under: got %0d/%b/%b required %0d/%b/%b",
                         i, count, push_ready, underflow, e.cnt, e.ready, e.under);
            end
        end
    endtask

    task automatic test_stall_underflow();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(1, 1, 32'h400, 0, 32'h404, 0, 0, 0, 0));
        rows.push_back(mk(1, 1, 32'h500, 0, 32'h504, 1, 1, 32'h500, 1));
        rows.push_back(mk(0, 0, 0, 0, 0, 1, 0, 32'h999, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h777, 0));
        rows.push_back(mk(1, 0, 32'h440, 1, 32'h480, 1, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h480, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = exp_q.pop_front();
            checks++;
            if (obs_bundle() !== e.bundle) begin
                fails++;
                $display("[TB] FAIL stall[%0d] bundle: got %h required %h", i, obs_bundle(), e.bundle);
            end
            checks++;
            if ({count, push_ready, underflow} !== {e.cnt, e.ready, e.under}) begin
                fails++;
                $display("[TB] FAIL stall[%0d] cnt/ready/under: got %0d/%b/%b required %0d/%b/%b",
                         i, count, push_ready, underflow, e.cnt, e.ready, e.under);
            end
        end
    endtask

    task automatic test_reset_recover();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(1, 1, 32'h600, 1, 32'h640, 0, 0, 0, 0));
        rows.push_back(mk(1, 1, 32'h610, 0, 32'h614, 0, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = exp_q.pop_front();
            checks++;
            if (obs_bundle() !== e.bundle) begin
                fails++;
                $display("[TB] FAIL recover[%0d] bundle: got %h required %h", i, obs_bundle(), e.bundle);
            end
            checks++;
            if ({count, push_ready, underflow} !== {e.cnt, e.ready, e.under}) begin
                fails++;
                $display("[TB] FAIL recover[%0d] cnt/ready/under: got %0d/%b/%b required %0d/%b/%b",
                         i, count, push_ready, underflow, e.cnt, e.ready, e.under);
            end
        end
        // now inside the RECOVER cycle, well before the next clock edge
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({obs_bundle(), count, underflow, push_ready} !== {100'd0, 3'd0, 1'b0, 1'b1}) begin
            fails++;
            $display("[TB] FAIL async_reset: got %h/%0d/%b/%b required 0/0/0/1",
                     obs_bundle(), count, underflow, push_ready);
        end
        @(posedge clk); #3;
        rst = 1'b0;
        mq.delete(); exp_q.delete();
        m_under = 1'b0; m_recover = 1'b0;
        @(posedge clk); #1;
        rows.delete();
        rows.push_back(mk(1, 1, 32'h700, 0, 32'h704, 0, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = exp_q.pop_front();
            checks++;
            if (obs_bundle() !== e.bundle) begin
                fails++;
                $display("[TB] FAIL after_reset[%0d] bundle: got %h required %h", i, obs_bundle(), e.bundle);
            end
            checks++;
            if ({count, push_ready, underflow} !== {e.cnt, e.ready, e.under}) begin
                fails++;
                $display("[TB] FAIL after_reset[%0d] cnt/ready/under: got %0d/%b/%b required %0d/%b/%b",
                         i, count, push_ready, underflow, e.cnt, e.ready, e.under);
            end
        end
    endtask

    initial begin
        $display("[TB] branch_resolve_queue bench start");
        test_reset();
        test_correct_prediction();
        test_mispredict();
        test_fill_wrap();
        test_stall_underflow();
        test_reset_recover();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
